// File: rtl/shift_rotate_unit.sv
// -----------------------------------------------------------------------------
// shift_rotate_unit
//
// Multi-cycle shift/rotate execution unit. A command is accepted through a
// valid/ready handshake. The unit then performs one 1-bit step per cycle until
// the effective count is used up. It presents the result with carry, sign and
// zero flags until the consumer takes it.
//
// Modes: 000 ROL, 001 ROR, 010 SHL, 011 SHR, 100 SAR, 101 RCL, 110 RCR,
//        111 reserved.
//
// Configuration macro: SHIFT_ROTATE_CARRY_EN
//   defined   - RCL/RCR rotate through the carry flag ({cf, r} is W+1 bits).
//   undefined - RCL/RCR behave as reserved: n = 0, r = a, cf = cf_prev.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_valid  command valid
//   start_ready  unit idle, command can be accepted
//   mode [2:0]   operation select
//   a    [W-1:0] operand
//   b    [W-1:0] unsigned shift/rotate count
//   cf_prev      incoming carry flag
//   res_valid    result and flags valid
//   res_ready    consumer accepts result
//   r    [W-1:0] result
//   cf           carry flag
//   sf           sign flag, r[W-1]
//   zf           zero flag, r == 0
// -----------------------------------------------------------------------------
module shift_rotate_unit #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [2:0]   mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cf_prev,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] r,
    output logic         cf,
    output logic         sf,
    output logic         zf
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    typedef enum logic [2:0] {
        M_ROL = 3'b000,
        M_ROR = 3'b001,
        M_SHL = 3'b010,
        M_SHR = 3'b011,
        M_SAR = 3'b100,
        M_RCL = 3'b101,
        M_RCR = 3'b110,
        M_RSV = 3'b111
    } mode_t;

    // The count is kept one bit wider than the operand so it can hold W+1,
    // the largest rotate-through-carry count.
    localparam logic [W:0] C_W  = (W + 1)'(W);
    localparam logic [W:0] C_W1 = (W + 1)'(W + 1);

    state_t       r_state;
    state_t       w_state_nxt;
    mode_t        r_mode;
    logic [W-1:0] r_val;
    logic         r_cf;
    logic [W:0]   r_cnt;

    logic         w_accept;
    logic [W:0]   w_b_ext;
    logic [W:0]   w_n;
    logic [W-1:0] w_step_val;
    logic         w_step_cf;

    assign w_accept = start_valid && (r_state == S_IDLE);
    assign w_b_ext  = {1'b0, b};

    // Effective count loaded on accept.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_n = '0;
        case (mode_t'(mode))
            M_ROL, M_ROR:        w_n = w_b_ext % C_W;
            M_SHL, M_SHR, M_SAR: w_n = (w_b_ext > C_W) ? C_W : w_b_ext;
`ifdef SHIFT_ROTATE_CARRY_EN
            M_RCL, M_RCR:        w_n = w_b_ext % C_W1;
`endif
            default:             w_n = '0;
        endcase
    end

    // One 1-bit step of the captured operation.
    always_comb begin
        w_step_val = r_val;
        w_step_cf  = r_cf;
        case (r_mode)
            M_ROL: begin
                w_step_val = {r_val[W-2:0], r_val[W-1]};
                w_step_cf  = r_val[W-1];
            end
            M_ROR: begin
                w_step_val = {r_val[0], r_val[W-1:1]};
                w_step_cf  = r_val[0];
            end
            M_SHL: begin
                w_step_val = {r_val[W-2:0], 1'b0};
                w_step_cf  = r_val[W-1];
            end
            M_SHR: begin
                w_step_val = {1'b0, r_val[W-1:1]};
                w_step_cf  = r_val[0];
            end
            M_SAR: begin
                w_step_val = {r_val[W-1], r_val[W-1:1]};
                w_step_cf  = r_val[0];
            end
`ifdef SHIFT_ROTATE_CARRY_EN
            M_RCL: begin
                w_step_val = {r_val[W-2:0], r_cf};
                w_step_cf  = r_val[W-1];
            end
            M_RCR: begin
                w_step_val = {r_cf, r_val[W-1:1]};
                w_step_cf  = r_val[0];
            end
`endif
            default: begin
                w_step_val = r_val;
                w_step_cf  = r_cf;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == '0) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture on accept, then step until the count reaches zero.
    // With n == 0 no step happens, so r = a and cf = cf_prev fall out directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val  <= '0;
            r_cf   <= 1'b0;
            r_cnt  <= '0;
            r_mode <= M_ROL;
        end else if (w_accept) begin
            r_val  <= a;
            r_cf   <= cf_prev;
            r_cnt  <= w_n;
            r_mode <= mode_t'(mode);
        end else if ((r_state == S_SHIFT) && (r_cnt != '0)) begin
            r_val  <= w_step_val;
            r_cf   <= w_step_cf;
            r_cnt  <= r_cnt - (W + 1)'(1);
        end
    end

    assign r  = r_val;
    assign cf = r_cf;
    assign sf = r_val[W-1];
    assign zf = (r_val == '0);

endmodule
